// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared constants and helpers for the multi-channel key debouncer.
//   CLK_FREQ_Hz, SAMPLE_HZ, N_SAMPLES, LONG_TICKS : default parameter values
//   LONG_CNT_W                                   : width of per-key hold counter
//   tick_cnt_w()                                 : width of the shared tick divider
// ---------------------------------------------------------------------------
package key_pkg;

    localparam int CLK_FREQ_Hz = 27000000;
    localparam int SAMPLE_HZ   = 100;
    localparam int N_SAMPLES   = 3;
    localparam int LONG_TICKS  = 100;
    localparam int LONG_CNT_W  = 16;

    // Width needed to count 0..DIV-1 where DIV = clk_hz / sample_hz.
    function automatic int tick_cnt_w(input int clk_hz, input int sample_hz);
        int div;
        div = clk_hz / sample_hz;
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/key_db_chan.sv
// ---------------------------------------------------------------------------
// key_db_chan
// One debounced key channel: 2-flop synchroniser, sample history, symmetric
// N-of-N debounce decision, registered press/release pulses and an optional
// long-press detector (enabled by defining KEY_DB_LONG_PRESS_EN).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   tick_i       : one-cycle sample strobe from the shared divider
//   key_i        : raw asynchronous key level
//   key_db_o     : debounced level
//   press_o      : one-cycle pulse on idle -> active transition
//   release_o    : one-cycle pulse on active -> idle transition
//   long_o       : one-cycle pulse when the hold reaches LONG_TICKS ticks
// ---------------------------------------------------------------------------
module key_db_chan #(
    parameter logic RST_VALUE  = 1'b0,
    parameter int   N_SAMPLES  = 3,
    parameter int   LONG_TICKS = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic key_i,
    output logic key_db_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);
    import key_pkg::*;

    if (N_SAMPLES < 2 || N_SAMPLES > 16) begin : g_bad_n_samples
        $error("key_db_chan: N_SAMPLES out of range 2..16");
    end
    if (LONG_TICKS < 1 || LONG_TICKS > 65535) begin : g_bad_long_ticks
        $error("key_db_chan: LONG_TICKS out of range 1..65535");
    end

    logic [1:0]           sync_q;
    logic [N_SAMPLES-1:0] hist_q, hist_d;
    logic                 db_q, db_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;

    always_comb begin
        hist_d = hist_q;
        if (tick_i) begin
            hist_d = {hist_q[N_SAMPLES-2:0], sync_q[1]};
        end
        // Any mixed history holds the current level, which gives hysteresis
        // in both directions.
        db_d = db_q;
        if (&hist_q) begin
            db_d = 1'b1;
        end else if (~|hist_q) begin
            db_d = 1'b0;
        end
        press_d   = (db_d != db_q) && (db_d != RST_VALUE);
        release_d = (db_d != db_q) && (db_d == RST_VALUE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= {2{RST_VALUE}};
            hist_q    <= {N_SAMPLES{RST_VALUE}};
            db_q      <= RST_VALUE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_i};
            hist_q    <= hist_d;
            db_q      <= db_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_db_o  = db_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef KEY_DB_LONG_PRESS_EN
    localparam logic [LONG_CNT_W-1:0] LONG_LIM = LONG_CNT_W'(LONG_TICKS);

    logic [LONG_CNT_W-1:0] hold_q, hold_d;
    logic                  long_q, long_d;

    // Counter saturates at LONG_LIM so each hold yields a single pulse.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (db_q == RST_VALUE) begin
            hold_d = '0;
        end else if (tick_i && (hold_q != LONG_LIM)) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_q == (LONG_LIM - 1'b1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/key_db_multi.sv
// ---------------------------------------------------------------------------
// key_db_multi
// N_KEYS independent key debouncers sharing one sample-tick divider.
// Optional long-press detection is enabled by defining KEY_DB_LONG_PRESS_EN;
// otherwise long_o is constant 0.
// Ports:
//   clk        : single clock
//   rst        : asynchronous active-high reset
//   key_i      : raw key levels            [N_KEYS]
//   key_db_o   : debounced key levels      [N_KEYS]
//   press_o    : press pulses              [N_KEYS]
//   release_o  : release pulses            [N_KEYS]
//   long_o     : long-press pulses         [N_KEYS]
// ---------------------------------------------------------------------------
module key_db_multi #(
    parameter int   N_KEYS      = 4,
    parameter logic RST_VALUE   = 1'b0,
    parameter int   CLK_FREQ_Hz = key_pkg::CLK_FREQ_Hz,
    parameter int   SAMPLE_HZ   = key_pkg::SAMPLE_HZ,
    parameter int   N_SAMPLES   = key_pkg::N_SAMPLES,
    parameter int   LONG_TICKS  = key_pkg::LONG_TICKS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_i,
    output logic [N_KEYS-1:0] key_db_o,
    output logic [N_KEYS-1:0] press_o,
    output logic [N_KEYS-1:0] release_o,
    output logic [N_KEYS-1:0] long_o
);
    import key_pkg::*;

    localparam int DIV   = CLK_FREQ_Hz / SAMPLE_HZ;
    localparam int CNT_W = tick_cnt_w(CLK_FREQ_Hz, SAMPLE_HZ);
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);

    if (N_KEYS < 1 || N_KEYS > 32) begin : g_bad_n_keys
        $error("key_db_multi: N_KEYS out of range 1..32");
    end
    if (DIV < 2) begin : g_bad_div
        $error("key_db_multi: CLK_FREQ_Hz/SAMPLE_HZ must be at least 2");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    // Tick is a clock-enable, not a clock: it marks the cycle in which the
    // divider wraps, so the first tick after reset lands DIV cycles later.
    assign tick  = (cnt_q == DIV_M1);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_db_chan #(
            .RST_VALUE (RST_VALUE),
            .N_SAMPLES (N_SAMPLES),
            .LONG_TICKS(LONG_TICKS)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .tick_i   (tick),
            .key_i    (key_i[i]),
            .key_db_o (key_db_o[i]),
            .press_o  (press_o[i]),
            .release_o(release_o[i]),
            .long_o   (long_o[i])
        );
    end

endmodule

// File: tb/tb_key_db_multi.sv
// ---------------------------------------------------------------------------
// tb_key_db_multi
// Self-checking bench for key_db_multi with DIV=10, N_SAMPLES=3, N_KEYS=4,
// RST_VALUE=0, LONG_TICKS=5. A behavioural model tracks sample times, runs of
// equal samples and hold time per key; outputs are compared every cycle, and
// directed scenarios add targeted checks.
// ---------------------------------------------------------------------------
module tb_key_db_multi;

    localparam int NK  = 4;
    localparam int DIV = 10;
    localparam int NS  = 3;
    localparam int LT  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NK-1:0] key_i = '0;
    logic [NK-1:0] key_db_o, press_o, release_o, long_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    key_db_multi #(
        .N_KEYS     (NK),
        .RST_VALUE  (1'b0),
        .CLK_FREQ_Hz(1000),
        .SAMPLE_HZ  (100),
        .N_SAMPLES  (NS),
        .LONG_TICKS (LT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_i    (key_i),
        .key_db_o (key_db_o),
        .press_o  (press_o),
        .release_o(release_o),
        .long_o   (long_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_cyc;
    logic [NK-1:0] m_d1, m_d2;        // key level one and two edges back
    logic [NK-1:0] run_val;           // value of the current run of samples
    int            run_len [NK];      // length of that run
    int            hold    [NK];      // ticks held since press
    logic [NK-1:0] exp_db, exp_press, exp_rel, exp_long;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = 0; m_d1 = '0; m_d2 = '0; run_val = '0;
            exp_db = '0; exp_press = '0; exp_rel = '0; exp_long = '0;
            for (int c = 0; c < NK; c++) begin
                run_len[c] = NS;
                hold[c]    = 0;
            end
        end else begin
            m_cyc++;
            exp_press = '0; exp_rel = '0; exp_long = '0;
            for (int c = 0; c < NK; c++) begin
`ifdef KEY_DB_LONG_PRESS_EN
                if (!exp_db[c]) hold[c] = 0;
                else if ((m_cyc % DIV == 0) && hold[c] < LT) begin
                    hold[c]++;
                    if (hold[c] == LT) exp_long[c] = 1'b1;
                end
`endif
                // New level is accepted one edge after the run reaches NS.
                if (run_len[c] >= NS && run_val[c] != exp_db[c]) begin
                    exp_db[c] = run_val[c];
                    if (run_val[c]) exp_press[c] = 1'b1;
                    else            exp_rel[c]   = 1'b1;
                end
                // Sample taken on this tick is the key level two edges ago.
                if (m_cyc % DIV == 0) begin
                    if (m_d2[c] == run_val[c]) run_len[c]++;
                    else begin
                        run_val[c] = m_d2[c];
                        run_len[c] = 1;
                    end
                end
            end
            m_d2 = m_d1;
            m_d1 = key_i;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("db",      key_db_o,  exp_db);
            chk("press",   press_o,   exp_press);
            chk("release", release_o, exp_rel);
            chk("long",    long_o,    exp_long);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk); #2 rst = 1'b1;
        repeat (n) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int found, cnt, nrel, nlong, t_press, t_long, t_last;

        #1 rst = 1'b1;
        idle(3);
        chk("rst_db",   key_db_o,  0);
        chk("rst_prs",  press_o,   0);
        chk("rst_rel",  release_o, 0);
        chk("rst_long", long_o,    0);
        chk_en = 1'b1;
        #2 rst = 1'b0;

        // Clean press right after reset release.
        @(negedge clk); key_i[0] = 1'b1;
        found = 0; cnt = 0;
        for (int i = 0; i < 32 && !found; i++) begin
            @(negedge clk);
            if (press_o[0]) cnt++;
            if (key_db_o[0]) found = 1;
        end
        chk("clean_lat", found, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (press_o[0]) cnt++;
        end
        chk("clean_press_cnt", cnt, 1);
        chk("clean_others", key_db_o[3:1], 0);
        key_i[0] = 1'b0;
        idle(45);

        // Bounce on key 1: toggles every 7 cycles for 60 cycles.
        cnt = 0; t_press = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i % 7 == 0) key_i[1] = ~key_i[1];
            if (press_o[1]) cnt++;
        end
        key_i[1] = 1'b1;
        t_last = cyc;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (press_o[1]) begin cnt++; t_press = cyc; end
        end
        chk("bounce_press_cnt", cnt, 1);
        chk("bounce_after_stable", t_press > t_last, 1);
        key_i[1] = 1'b0;
        idle(45);

        // Glitch on key 2: 15 cycles high.
        cnt = 0;
        @(negedge clk); key_i[2] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 14) key_i[2] = 1'b0;
            if (key_db_o[2] || press_o[2] || release_o[2]) cnt++;
        end
        chk("glitch_quiet", cnt, 0);

        // Simultaneous press and release of all keys.
        key_i = 4'b1111;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (press_o != 0) begin
                found = 1;
                chk("sim_press", press_o, 4'b1111);
            end
        end
        chk("sim_press_seen", found, 1);
        idle(5);
        key_i = 4'b0000;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (release_o != 0) begin
                found = 1;
                chk("sim_release", release_o, 4'b1111);
            end
        end
        chk("sim_release_seen", found, 1);
        idle(45);

        // Reset while key 0 is debounced high.
        key_i[0] = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (key_db_o[0]) found = 1;
        end
        chk("rst_mid_pre", found, 1);
        @(negedge clk); #2 rst = 1'b1;
        #1 chk("rst_mid_async_db", key_db_o, 0);
        nrel = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (release_o != 0) nrel++;
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (release_o != 0) nrel++;
        end
        chk("rst_mid_no_release", nrel, 0);
        key_i[0] = 1'b0;
        idle(80);

        // Long press on key 3.
        key_i[3] = 1'b1;
        found = 0; t_press = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (press_o[3]) begin found = 1; t_press = cyc; end
        end
        chk("long_press_seen", found, 1);
        nlong = 0; t_long = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (long_o[3]) begin nlong++; t_long = cyc; end
        end
`ifdef KEY_DB_LONG_PRESS_EN
        chk("long_cnt", nlong, 1);
        chk("long_delay", (t_long - t_press >= 4*DIV) && (t_long - t_press <= 6*DIV), 1);
`else
        chk("long_cnt", nlong, 0);
`endif
        key_i[3] = 1'b0;
        idle(45);

        // Randomised activity with one reset in the middle; the model checks.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int b = 0; b < NK; b++)
                if ($urandom_range(0, 39) == 0) key_i[b] = ~key_i[b];
            if (i == 1500) begin
                #2 rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end
        end
        key_i = '0;
        idle(50);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_db_multi.md
KEY_DB_MULTI -- requirements
Module: key_db_multi

Interface
REQ-001 Parameter N_KEYS, default 4: number of independent key channels, legal range 1..32.
REQ-002 Parameter RST_VALUE, default 1'b0: released (idle) key level; the reset value of all sample and debounced state.
REQ-003 Parameter CLK_FREQ_Hz, default 27000000: clk frequency.
REQ-004 Parameter SAMPLE_HZ, default 100: sampling rate; DIV = CLK_FREQ_Hz/SAMPLE_HZ, DIV >= 2.
REQ-005 Parameter N_SAMPLES, default 3: consecutive equal samples needed to accept a level change, legal range 2..16.
REQ-006 Parameter LONG_TICKS, default 100: sample ticks a key must be held before it counts as a long press, legal range 1..65535.
REQ-007 Port clk, input, 1: single clock for all logic.
REQ-008 Port rst, input, 1: asynchronous, active-high reset.
REQ-009 Port key_i, input, N_KEYS: raw asynchronous key levels.
REQ-010 Port key_db_o, output, N_KEYS: debounced key levels.
REQ-011 Port press_o, output, N_KEYS: one-cycle pulse when a key is pressed.
REQ-012 Port release_o, output, N_KEYS: one-cycle pulse when a key is released.
REQ-013 Port long_o, output, N_KEYS: one-cycle pulse when a key becomes a long press (LONG_PRESS_EN only; tied 0 otherwise).

Function
REQ-014 Each key_i bit SHALL pass through a 2-flop synchroniser reset to RST_VALUE; no other logic samples key_i directly.
REQ-015 A modulo-DIV counter SHALL assert a one-cycle sample_tick when it wraps from DIV-1 to 0; no derived or gated clock is used.
REQ-016 On sample_tick, each channel SHALL shift its synchronised level into an N_SAMPLES-bit history register.
REQ-017 Debounce decision: key_db_o[i] takes a new level only when all N_SAMPLES history bits equal that level and it differs from the current key_db_o[i]; otherwise key_db_o[i] holds.
REQ-018 Debounce is symmetric: press and release both require N_SAMPLES consecutive equal samples (hysteresis).
REQ-019 key_db_o[i] SHALL update on the clock edge after the tick that completes the N-th matching sample, giving a worst-case latency of 2 + N_SAMPLES*DIV cycles after an input change.
REQ-020 press_o[i] SHALL be high for exactly the one cycle in which key_db_o[i] changes from RST_VALUE to ~RST_VALUE; release_o[i] SHALL do the same for the opposite change.
REQ-021 Channels SHALL be fully independent; any combination of press/release/long pulses may occur on different bits in the same cycle.
REQ-022 A glitch shorter than N_SAMPLES consecutive ticks SHALL produce no change on any output.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 While rst is high, the following SHALL be held at their reset values: synchronisers, history registers and key_db_o at RST_VALUE; tick counter, long counters, press_o, release_o and long_o at 0.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL discard partial state, and no pulse SHALL be emitted on entry to or exit from reset.
REQ-026 The first sample_tick after reset release SHALL occur DIV cycles after release.

Configuration
REQ-027 Macro KEY_DB_LONG_PRESS_EN, when defined, enables the long-press feature.
- Each channel has a 16-bit hold counter, cleared while key_db_o[i] == RST_VALUE.
- While the key is held, the counter increments on each sample_tick.
- long_o[i] pulses for one cycle when the counter reaches LONG_TICKS.
- The counter then saturates, so there is one pulse per hold.
REQ-028 Without KEY_DB_LONG_PRESS_EN, the hold counters are not instantiated and long_o SHALL be constant 0.

Structure
REQ-029 Shared package key_pkg SHALL hold:
- the default constants (CLK_FREQ_Hz, SAMPLE_HZ, N_SAMPLES, LONG_TICKS);
- the long-counter width constant LONG_CNT_W = 16;
- a function computing the tick-counter width as $clog2(DIV).
REQ-030 Per-channel logic (synchroniser, history, decision, edge pulses, long counter) SHALL be a sub-module key_db_chan, generated N_KEYS times; the tick counter is shared at the top level.

Verification
REQ-031 Benches SHALL use CLK_FREQ_Hz=1000 and SAMPLE_HZ=100 (DIV=10), N_SAMPLES=3, N_KEYS=4, RST_VALUE=0.
REQ-032 Clean press: key_i[0] 0->1 and held -> key_db_o[0]=1 within 32 cycles; press_o[0] high for exactly 1 cycle; other bits stay 0.
REQ-033 Bounce: key_i[1] toggles every 7 cycles for 60 cycles, then holds 1 -> exactly one press_o[1] pulse, after the stable period.
REQ-034 Glitch: key_i[2] high for 15 cycles (at most 2 ticks) -> key_db_o, press_o and release_o all stay 0.
REQ-035 Simultaneous: key_i=4'b1111 held, then 4'b0000 -> press_o=4'b1111 in one cycle, later release_o=4'b1111 in one cycle.
REQ-036 Reset mid-operation and long press:
- Reset: rst pulsed while key_db_o[0]=1 -> key_db_o=0 immediately (asynchronous), and no release_o pulse.
- Long press: with KEY_DB_LONG_PRESS_EN and LONG_TICKS=5, hold key 3 -> one long_o[3] pulse 5 ticks after press_o[3]; none after further holding.
